// File: rtl/freqtable_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | freqtable_arbiter_if: channel/ROM bundle for freqtable_arbiter.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface freqtable_arbiter_if #(
  parameter int NCH = 16,
  parameter int AW  = 10,
  parameter int DW  = 18
);
  logic [NCH-1:0]    req;
  logic [NCH*AW-1:0] addr;
  logic              rom_en;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_do;
  logic [NCH*DW-1:0] ch_out;
  logic [NCH-1:0]    done;
  logic [NCH-1:0]    pending;
  logic              overrun;
  logic              ovr_clr;

  // slave is the arbiter side; master is the channel/ROM environment side
  modport slave (
    input  req, addr, rom_do, ovr_clr,
    output rom_en, rom_addr, ch_out, done, pending, overrun
  );
  modport master (
    output req, addr, rom_do, ovr_clr,
    input  rom_en, rom_addr, ch_out, done, pending, overrun
  );
endinterface
`default_nettype wire

// File: rtl/freqtable_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | freqtable_arbiter: shares one synchronous freqtable ROM among NCH |
// | channels. FREQARB_FIXED_PRIO_EN selects fixed-priority grants.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module freqtable_arbiter #(
  parameter int NCH = 16,
  parameter int AW  = 10,
  parameter int DW  = 18
) (
  input  logic                clk,
  input  logic                rst_n,
  freqtable_arbiter_if.slave  bus
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] pend_q, pend_d;
  logic [AW-1:0]  addr_q [NCH];
  logic [AW-1:0]  addr_d [NCH];
  logic [DW-1:0]  chd_q  [NCH];
  logic [DW-1:0]  chd_d  [NCH];
  logic [NCH-1:0] done_q, done_d;
  logic           rd_vld_q, rd_vld_d;
  logic [PW-1:0]  rd_ch_q, rd_ch_d;
  logic           ovr_q, ovr_d;
  logic           ovr_evt;
  logic           gnt_vld;
  logic [PW-1:0]  gnt_idx;

`ifdef FREQARB_FIXED_PRIO_EN
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NCH-1; k >= 0; k--) begin
      if (pend_q[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(k);
      end
    end
  end
`else
  logic [PW-1:0] ptr_q, ptr_d;
  int            rr_idx;

  // Search upward from ptr, wrapping at NCH (NCH need not be a power of two)
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_idx  = 0;
    for (int k = 0; k < NCH; k++) begin
      rr_idx = int'(ptr_q) + k;
      if (rr_idx >= NCH) rr_idx = rr_idx - NCH;
      if (!gnt_vld && pend_q[rr_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(rr_idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (gnt_idx == PW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    pend_d   = pend_q;
    addr_d   = addr_q;
    chd_d    = chd_q;
    done_d   = '0;
    ovr_evt  = 1'b0;
    rd_vld_d = gnt_vld;
    rd_ch_d  = gnt_idx;
    if (gnt_vld) pend_d[gnt_idx] = 1'b0;
    // A new request re-arms the channel; it only overruns if the old one was not issued now
    for (int i = 0; i < NCH; i++) begin
      if (bus.req[i]) begin
        pend_d[i] = 1'b1;
        addr_d[i] = bus.addr[i*AW +: AW];
        if (pend_q[i] && !(gnt_vld && gnt_idx == PW'(i))) ovr_evt = 1'b1;
      end
    end
    ovr_d = ovr_q;
    if (bus.ovr_clr) ovr_d = 1'b0;
    if (ovr_evt)     ovr_d = 1'b1;
    if (rd_vld_q) begin
      chd_d[rd_ch_q]  = bus.rom_do;
      done_d[rd_ch_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      done_q   <= '0;
      rd_vld_q <= 1'b0;
      rd_ch_q  <= '0;
      ovr_q    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        addr_q[i] <= '0;
        chd_q[i]  <= '0;
      end
    end else begin
      pend_q   <= pend_d;
      done_q   <= done_d;
      rd_vld_q <= rd_vld_d;
      rd_ch_q  <= rd_ch_d;
      ovr_q    <= ovr_d;
      addr_q   <= addr_d;
      chd_q    <= chd_d;
    end
  end

  assign bus.rom_en   = gnt_vld;
  assign bus.rom_addr = gnt_vld ? addr_q[gnt_idx] : '0;
  assign bus.done     = done_q;
  assign bus.pending  = pend_q;
  assign bus.overrun  = ovr_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch_out
    assign bus.ch_out[i*DW +: DW] = chd_q[i];
  end
endmodule
`default_nettype wire

// File: tb/tb_freqtable_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_freqtable_arbiter: directed self-checking bench with ROM model.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_freqtable_arbiter;
  localparam int NCH = 16;
  localparam int AW  = 10;
  localparam int DW  = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  freqtable_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

  freqtable_arbiter #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {a[7:0], ~a} ^ 18'h15A5A;
  endfunction

  initial bus.rom_do = '0;
  always @(posedge clk) if (bus.rom_en) bus.rom_do <= rom_word(bus.rom_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.req = '0; bus.ovr_clr = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  function automatic logic [DW-1:0] slice(input int i);
    return bus.ch_out[i*DW +: DW];
  endfunction

  task automatic burst(input int base);
    for (int i = 0; i < NCH; i++) bus.addr[i*AW +: AW] = AW'(i*4 + base);
    bus.req = '1;
    step(1);
    bus.req = '0;
    for (int c = 0; c < NCH + 2; c++) begin
      if (c < NCH) begin
        chk($sformatf("burst%0d_en_%0d", base, c), bus.rom_en, 1);
        chk($sformatf("burst%0d_addr_%0d", base, c), bus.rom_addr, c*4 + base);
      end
      if (c >= 2) begin
        chk($sformatf("burst%0d_done_%0d", base, c-2), bus.done, 64'(1) << (c-2));
        chk($sformatf("burst%0d_data_%0d", base, c-2), slice(c-2), rom_word(AW'((c-2)*4 + base)));
      end else begin
        chk($sformatf("burst%0d_nodone_%0d", base, c), bus.done, 0);
      end
      step(1);
    end
    chk($sformatf("burst%0d_idle_en", base), bus.rom_en, 0);
    chk($sformatf("burst%0d_idle_done", base), bus.done, 0);
  endtask

  initial begin
    logic [NCH*DW-1:0] m;
    bus.req = '0; bus.addr = '0; bus.ovr_clr = 1'b0;
    step(2);
    // reset state
    chk("rst_en", bus.rom_en, 0);
    chk("rst_addr", bus.rom_addr, 0);
    chk("rst_chout", |bus.ch_out, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pend", bus.pending, 0);
    chk("rst_ovr", bus.overrun, 0);
    rst_n = 1'b1;
    step(1);

    // single uncontended request on channel 3
    bus.addr[3*AW +: AW] = 10'h045;
    bus.req = 16'h0008;
    step(1);
    bus.req = '0;
    chk("s_pend", bus.pending, 16'h0008);
    chk("s_en", bus.rom_en, 1);
    chk("s_addr", bus.rom_addr, 10'h045);
    step(1);
    chk("s_en2", bus.rom_en, 0);
    chk("s_pend2", bus.pending, 0);
    chk("s_done2", bus.done, 0);
    step(1);
    chk("s_done", bus.done, 16'h0008);
    chk("s_data", slice(3), rom_word(10'h045));
    m = '0; m[3*DW +: DW] = '1;
    chk("s_others", |(bus.ch_out & ~m), 0);
    chk("s_ovr", bus.overrun, 0);
    step(1);
    chk("s_done_end", bus.done, 0);

    // full bursts; second one starts at ch0 after the pointer wraps
    do_reset();
    burst(0);
    burst(1);

    // round-robin fairness with two requests held high
    bus.addr[1*AW +: AW] = 10'h101;
    bus.addr[2*AW +: AW] = 10'h202;
    bus.req = 16'h0006;
    step(1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rr_en_%0d", k), bus.rom_en, 1);
      chk($sformatf("rr_addr_%0d", k), bus.rom_addr, (k % 2 == 0) ? 10'h101 : 10'h202);
      step(1);
    end
    bus.req = '0;
    step(5);
    bus.ovr_clr = 1'b1;
    step(1);
    bus.ovr_clr = 1'b0;
    chk("rr_ovr_clr", bus.overrun, 0);

    // overrun: ch5 re-requested while ch1 is ahead of it
    do_reset();
    bus.addr[0*AW +: AW] = 10'h003;
    bus.addr[1*AW +: AW] = 10'h004;
    bus.req = 16'h0003;
    step(1);
    chk("o_gnt0", bus.rom_addr, 10'h003);
    bus.addr[5*AW +: AW] = 10'h010;
    bus.req = 16'h0020;
    step(1);
    chk("o_gnt1", bus.rom_addr, 10'h004);
    chk("o_ovr0", bus.overrun, 0);
    bus.addr[5*AW +: AW] = 10'h020;
    step(1);
    bus.req = '0;
    chk("o_gnt5", bus.rom_addr, 10'h020);
    chk("o_ovr1", bus.overrun, 1);
    chk("o_done0", bus.done, 16'h0001);
    step(1);
    chk("o_idle", bus.rom_en, 0);
    chk("o_done1", bus.done, 16'h0002);
    step(1);
    chk("o_done5", bus.done, 16'h0020);
    chk("o_data5", slice(5), rom_word(10'h020));
    step(1);
    chk("o_done_end", bus.done, 0);
    bus.ovr_clr = 1'b1;
    step(1);
    bus.ovr_clr = 1'b0;
    chk("o_clr", bus.overrun, 0);
    // set wins over clear in the same cycle
    bus.req = 16'h0003;
    step(1);
    bus.req = 16'h0002;
    bus.ovr_clr = 1'b1;
    step(1);
    bus.req = '0;
    bus.ovr_clr = 1'b0;
    chk("o_setwins", bus.overrun, 1);
    step(4);
    bus.ovr_clr = 1'b1;
    step(1);
    bus.ovr_clr = 1'b0;
    chk("o_clr2", bus.overrun, 0);

    // request coincident with its own grant
    do_reset();
    bus.addr[7*AW +: AW] = 10'h077;
    bus.req = 16'h0080;
    step(1);
    chk("c_addr0", bus.rom_addr, 10'h077);
    bus.addr[7*AW +: AW] = 10'h0F7;
    step(1);
    bus.req = '0;
    chk("c_pend", bus.pending, 16'h0080);
    chk("c_addr1", bus.rom_addr, 10'h0F7);
    chk("c_ovr", bus.overrun, 0);
    step(1);
    chk("c_done0", bus.done, 16'h0080);
    chk("c_data0", slice(7), rom_word(10'h077));
    step(1);
    chk("c_done1", bus.done, 16'h0080);
    chk("c_data1", slice(7), rom_word(10'h0F7));
    step(1);
    chk("c_done_end", bus.done, 0);

    // reset while a read is in flight
    bus.addr[2*AW +: AW] = 10'h0AA;
    bus.req = 16'h0004;
    step(1);
    bus.req = '0;
    chk("r_gnt", bus.rom_en, 1);
    step(1);
    rst_n = 1'b0;
    #1;
    chk("r_en", bus.rom_en, 0);
    chk("r_chout", |bus.ch_out, 0);
    chk("r_done", bus.done, 0);
    chk("r_pend", bus.pending, 0);
    step(1);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("r_nodone_%0d", k), bus.done, 0);
      chk($sformatf("r_chout_%0d", k), |bus.ch_out, 0);
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
